// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst master
//
// Ports:
//   clk, rst (sync, active-low)
//   cmd_*           command handshake: direction, start address, len (beats-1)
//   wd_*            write-beat stream in (data, strobes, valid/ready)
//   rd_*            read-beat stream out (data, last, valid/ready)
//   done*           one-cycle completion pulse with response and protocol-error status
//   aw_*/w_*/b_*    AXI4 write address, write data and write response channels
//   ar_*/r_*        AXI4 read address and read data channels

module axi_burst_master #(
  parameter int                  DATA_WIDTH    = 64,
  parameter int                  ADDRESS_WIDTH = 32,
  parameter int                  ID_WIDTH      = 1,
  parameter logic [ID_WIDTH-1:0] MASTER_ID     = '0
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [7:0]                cmd_len,

  input  logic [DATA_WIDTH-1:0]     wd_data,
  input  logic [DATA_WIDTH/8-1:0]   wd_strb,
  input  logic                      wd_valid,
  output logic                      wd_ready,

  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic                      rd_valid,
  input  logic                      rd_ready,

  output logic                      done,
  output logic [1:0]                done_resp,
  output logic                      done_err,

  output logic [ID_WIDTH-1:0]       aw_id,
  output logic [ADDRESS_WIDTH-1:0]  aw_addr,
  output logic [7:0]                aw_len,
  output logic [2:0]                aw_size,
  output logic [1:0]                aw_burst,
  output logic [3:0]                aw_cache,
  output logic [2:0]                aw_prot,
  output logic [3:0]                aw_qos,
  output logic [3:0]                aw_region,
  output logic                      aw_valid,
  input  logic                      aw_ready,

  output logic [DATA_WIDTH-1:0]     w_data,
  output logic [DATA_WIDTH/8-1:0]   w_strb,
  output logic                      w_last,
  output logic                      w_valid,
  input  logic                      w_ready,

  input  logic [ID_WIDTH-1:0]       b_id,
  input  logic [1:0]                b_resp,
  input  logic                      b_valid,
  output logic                      b_ready,

  output logic [ID_WIDTH-1:0]       ar_id,
  output logic [ADDRESS_WIDTH-1:0]  ar_addr,
  output logic [7:0]                ar_len,
  output logic [2:0]                ar_size,
  output logic [1:0]                ar_burst,
  output logic [3:0]                ar_cache,
  output logic [2:0]                ar_prot,
  output logic [3:0]                ar_qos,
  output logic [3:0]                ar_region,
  output logic                      ar_valid,
  input  logic                      ar_ready,

  input  logic [ID_WIDTH-1:0]       r_id,
  input  logic [DATA_WIDTH-1:0]     r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_last,
  input  logic                      r_valid,
  output logic                      r_ready
);

  localparam int                     BEAT_BYTES = DATA_WIDTH / 8;
  localparam int                     SIZE       = $clog2(BEAT_BYTES);
  // Clears the byte-offset-within-beat bits so bursts start beat-aligned.
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~(ADDRESS_WIDTH'(BEAT_BYTES - 1));
  localparam logic [1:0]             RESP_OKAY  = 2'b00;
  localparam logic [1:0]             BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R
  } state_t;

  state_t                     state;
  logic [7:0]                 count;
  logic [7:0]                 len_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic                       aw_valid_q;
  logic                       ar_valid_q;
  logic                       b_ready_q;
  logic                       done_q;
  logic [1:0]                 resp_q;
  logic                       err_q;

  logic                       in_w;
  logic                       in_r;
  logic                       last_beat;
  logic                       w_hs;
  logic                       r_hs;

  assign in_w      = (state == S_W);
  assign in_r      = (state == S_R);
  assign last_beat = (count == len_q);

  // Data phases are pure pass-through between the streams and the AXI channels.
  assign w_valid   = in_w & wd_valid;
  assign wd_ready  = in_w & w_ready;
  assign w_data    = wd_data;
  assign w_strb    = wd_strb;
  assign w_last    = in_w & last_beat;
  assign w_hs      = in_w & wd_valid & w_ready;

  assign rd_valid  = in_r & r_valid;
  assign r_ready   = in_r & rd_ready;
  assign rd_data   = r_data;
  assign rd_last   = in_r & last_beat;
  assign r_hs      = in_r & r_valid & rd_ready;

  assign cmd_ready = (state == S_IDLE);

  assign aw_id     = MASTER_ID;
  assign aw_addr   = addr_q;
  assign aw_len    = len_q;
  assign aw_size   = 3'(SIZE);
  assign aw_burst  = BURST_INCR;
  assign aw_cache  = '0;
  assign aw_prot   = '0;
  assign aw_qos    = '0;
  assign aw_region = '0;
  assign aw_valid  = aw_valid_q;

  assign ar_id     = MASTER_ID;
  assign ar_addr   = addr_q;
  assign ar_len    = len_q;
  assign ar_size   = 3'(SIZE);
  assign ar_burst  = BURST_INCR;
  assign ar_cache  = '0;
  assign ar_prot   = '0;
  assign ar_qos    = '0;
  assign ar_region = '0;
  assign ar_valid  = ar_valid_q;

  assign b_ready   = b_ready_q;
  assign done      = done_q;
  assign done_resp = resp_q;
  assign done_err  = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      count      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= RESP_OKAY;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr & ADDR_MASK;
            len_q  <= cmd_len;
            count  <= '0;
            resp_q <= RESP_OKAY;
            err_q  <= 1'b0;
            if (cmd_write) begin
              aw_valid_q <= 1'b1;
              state      <= S_AW;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= S_AR;
            end
          end
        end
        S_AW: begin
          if (aw_ready) begin
            aw_valid_q <= 1'b0;
            state      <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            count <= count + 8'd1;
            if (last_beat) begin
              b_ready_q <= 1'b1;
              state     <= S_B;
            end
          end
        end
        S_B: begin
          if (b_valid) begin
            b_ready_q <= 1'b0;
            done_q    <= 1'b1;
            resp_q    <= b_resp;
            err_q     <= (b_id != MASTER_ID);
            state     <= S_IDLE;
          end
        end
        S_AR: begin
          if (ar_ready) begin
            ar_valid_q <= 1'b0;
            state      <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            count <= count + 8'd1;
            // Keep the first error response; later ones do not overwrite it.
            if (resp_q == RESP_OKAY && r_resp != RESP_OKAY) begin
              resp_q <= r_resp;
            end
            if (r_id != MASTER_ID || r_last != last_beat) begin
              err_q <= 1'b1;
            end
            // The beat count, not r_last, terminates the burst.
            if (last_beat) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - directed self-checking bench for axi_burst_master

module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        wd_valid, wd_ready;
  logic [63:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic        done_err;
  logic [0:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_cache;
  logic [2:0]  aw_prot;
  logic [3:0]  aw_qos, aw_region;
  logic        aw_valid, aw_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last, w_valid, w_ready;
  logic [0:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [0:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_cache;
  logic [2:0]  ar_prot;
  logic [3:0]  ar_qos, ar_region;
  logic        ar_valid, ar_ready;
  logic [0:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last, r_valid, r_ready;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_data(wd_data), .wd_strb(wd_strb), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_qos(aw_qos),
    .aw_region(aw_region), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos),
    .ar_region(ar_region), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a command at a negedge; returns at the negedge after acceptance.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input string name, input logic [31:0] addr, input int len,
                           input logic [63:0] base, input bit throttle,
                           input logic [0:0] bid, input logic [1:0] bresp,
                           input logic [31:0] exp_addr, input logic exp_err);
    int beat = 0;
    int cyc  = 0;
    bit tog  = 1'b1;
    bit bready_ok = 1'b1;
    issue_cmd(1'b1, addr, 8'(len));
    check({name, "_aw_valid"}, aw_valid, 1'b1);
    check({name, "_aw_addr"}, aw_addr, exp_addr);
    check({name, "_aw_len"}, aw_len, 64'(len));
    check({name, "_aw_size"}, aw_size, 3'd3);
    check({name, "_aw_burst"}, aw_burst, 2'd1);
    aw_ready = 1'b1;
    @(negedge clk);
    aw_ready = 1'b0;
    wd_valid = 1'b1;
    while (beat <= len && cyc < 1000) begin
      wd_data = base + 64'(beat);
      w_ready = throttle ? tog : 1'b1;
      tog = ~tog;
      #1;
      if (b_ready) bready_ok = 1'b0;
      if (w_valid && w_ready) begin
        check($sformatf("%s_wdata%0d", name, beat), w_data, base + 64'(beat));
        check($sformatf("%s_wlast%0d", name, beat), w_last, 64'(beat == len));
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    wd_valid = 1'b0;
    w_ready  = 1'b0;
    check({name, "_w_beats"}, 64'(beat), 64'(len + 1));
    check({name, "_bready_in_w"}, bready_ok, 1'b1);
    #1;
    check({name, "_bready_in_b"}, b_ready, 1'b1);
    b_valid = 1'b1;
    b_id    = bid;
    b_resp  = bresp;
    @(negedge clk);
    b_valid = 1'b0;
    b_id    = 1'b0;
    b_resp  = 2'd0;
    check({name, "_done"}, done, 1'b1);
    check({name, "_done_resp"}, done_resp, bresp);
    check({name, "_done_err"}, done_err, exp_err);
    check({name, "_bready_after"}, b_ready, 1'b0);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic run_read(input string name, input logic [31:0] addr, input int len,
                          input int stall_beat, input int stall_n,
                          input int resp_beat, input logic [1:0] resp_val,
                          input int bad_last, input logic [1:0] exp_resp,
                          input logic exp_err);
    int beat = 0;
    int cyc  = 0;
    int stalled = 0;
    bit crdy_ok = 1'b1;
    bit last_ok = 1'b1;
    bit data_ok = 1'b1;
    issue_cmd(1'b0, addr, 8'(len));
    check({name, "_ar_valid"}, ar_valid, 1'b1);
    check({name, "_ar_len"}, ar_len, 64'(len));
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid  = 1'b1;
    while (beat <= len && cyc < 2000) begin
      r_data = 64'hD000 + 64'(beat);
      r_last = (bad_last >= 0) ? (beat == bad_last) : (beat == len);
      r_resp = (beat == resp_beat) ? resp_val : 2'd0;
      if (beat == stall_beat && stalled < stall_n) begin
        rd_ready = 1'b0;
        stalled++;
      end else begin
        rd_ready = 1'b1;
      end
      #1;
      if (cmd_ready) crdy_ok = 1'b0;
      if (rd_valid && rd_ready) begin
        if (rd_data !== 64'hD000 + 64'(beat)) data_ok = 1'b0;
        if (rd_last !== (beat == len)) last_ok = 1'b0;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    r_valid  = 1'b0;
    rd_ready = 1'b0;
    r_last   = 1'b0;
    r_resp   = 2'd0;
    check({name, "_r_beats"}, 64'(beat), 64'(len + 1));
    check({name, "_rd_data_order"}, data_ok, 1'b1);
    check({name, "_rd_last_pos"}, last_ok, 1'b1);
    check({name, "_cmd_ready_busy"}, crdy_ok, 1'b1);
    check({name, "_stall_cycles"}, 64'(stalled), 64'(stall_n));
    check({name, "_done"}, done, 1'b1);
    check({name, "_done_resp"}, done_resp, exp_resp);
    check({name, "_done_err"}, done_err, exp_err);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int beat;
    int cyc;
    bit done_seen;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_data = '0; wd_strb = 8'hFF; wd_valid = 1'b0; rd_ready = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_id = '0; b_resp = '0; b_valid = 1'b0;
    ar_ready = 1'b0; r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b0; r_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_aw_valid", aw_valid, 1'b0);
    check("rst_ar_valid", ar_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_done_resp", done_resp, 2'd0);
    check("rst_aw_addr", aw_addr, 32'd0);
    check("rst_aw_len", aw_len, 8'd0);
    check("rst_b_ready", b_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    run_write("wr1", 32'h0000_1004, 0, 64'h55, 1'b0, 1'b0, 2'd0, 32'h0000_1000, 1'b0);
    check("w_strb_pass", w_strb, 8'hFF);
    run_write("wr4", 32'h0000_2000, 3, 64'hA0, 1'b1, 1'b0, 2'd0, 32'h0000_2000, 1'b0);
    run_read("rd8", 32'h0000_3000, 7, 3, 2, 4, 2'd2, -1, 2'd2, 1'b0);
    run_read("rdlast", 32'h0000_4000, 3, -1, 0, -1, 2'd0, 1, 2'd0, 1'b1);
    run_write("wrbid", 32'h0000_5008, 1, 64'hB0, 1'b0, 1'b1, 2'd2, 32'h0000_5008, 1'b1);
    run_read("rd256", 32'h0001_0000, 255, -1, 0, -1, 2'd0, -1, 2'd0, 1'b0);

    // Reset in the middle of an 8-beat write, after three beats.
    issue_cmd(1'b1, 32'h0000_6000, 8'd7);
    aw_ready = 1'b1;
    @(negedge clk);
    aw_ready = 1'b0;
    wd_valid = 1'b1;
    w_ready  = 1'b1;
    beat = 0;
    cyc  = 0;
    while (beat < 3 && cyc < 20) begin
      wd_data = 64'hC0 + 64'(beat);
      #1;
      if (w_valid && w_ready) beat++;
      @(negedge clk);
      cyc++;
    end
    check("mid_beats_before_rst", 64'(beat), 64'd3);
    rst = 1'b0;
    @(negedge clk);
    check("mid_w_valid", w_valid, 1'b0);
    check("mid_aw_valid", aw_valid, 1'b0);
    check("mid_cmd_ready", cmd_ready, 1'b1);
    check("mid_wd_ready", wd_ready, 1'b0);
    rst = 1'b1;
    wd_valid = 1'b0;
    w_ready  = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("mid_no_done", done_seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Single-outstanding AXI4 master that drives the `memory` slave's AW/W/B/AR/R channels.
- Converts a simple command interface (address, length, direction) plus write-data/read-data streams into one INCR burst per command.
- Reports completion and response status.
- Sits directly upstream of `memory` and is the bench/system-side traffic source for it.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; must be 32 or 64.
- ADDRESS_WIDTH, 32, AXI address width.
- ID_WIDTH, 1, AXI ID width.
- MASTER_ID, 0, value driven on aw_id/ar_id and expected on b_id/r_id.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDRESS_WIDTH  start byte address.
- cmd_len  in  8  beats minus one (AXI len encoding).
- wd_data / wd_strb  in  DATA_WIDTH / DATA_WIDTH/8  write beat payload and byte strobes.
- wd_valid / wd_ready  in / out  1 / 1  write-data stream handshake.
- rd_data  out  DATA_WIDTH  read beat payload.
- rd_last  out  1  final read beat.
- rd_valid / rd_ready  out / in  1 / 1  read-data stream handshake.
- done  out  1  one-cycle pulse at end of command.
- done_resp  out  2  AXI response summary for the finished command.
- done_err  out  1  protocol error (ID mismatch or r_last misplacement).
- aw_id, aw_addr, aw_len, aw_size, aw_burst  out  ID_WIDTH, ADDRESS_WIDTH, 8, 3, 2  write address channel.
- aw_cache, aw_prot, aw_qos, aw_region  out  4, 3, 4, 4  tied 0.
- aw_valid / aw_ready  out / in  1 / 1.
- w_data, w_strb, w_last, w_valid  out  DATA_WIDTH, DATA_WIDTH/8, 1, 1.
- w_ready  in  1.
- b_id, b_resp, b_valid  in  ID_WIDTH, 2, 1.
- b_ready  out  1.
- ar_id, ar_addr, ar_len, ar_size, ar_burst  out  same widths as AW.
- ar_cache, ar_prot, ar_qos, ar_region  out  4, 3, 4, 4  tied 0.
- ar_valid / ar_ready  out / in  1 / 1.
- r_id, r_data, r_resp, r_last, r_valid  in  ID_WIDTH, DATA_WIDTH, 2, 1, 1.
- r_ready  out  1.

Behaviour:
- FSM states: IDLE, AW, W, B, AR, R.
- Reset (rst=0 at a clock edge):
  - state goes to IDLE regardless of current state, including mid-burst.
  - Beat counter and status clear.
  - All valid/ready outputs, done, done_err and rd_last go to 0; done_resp goes to 0.
  - Address/len outputs go to 0.
- cmd_ready = 1 only in IDLE.
- On cmd handshake, latch addr/len/dir, clear counter and status. Next state is AW (write) or AR (read).
- Address and size fields:
  - aw_addr/ar_addr = cmd_addr with the low log2(DATA_WIDTH/8) bits cleared.
  - aw_size/ar_size = log2(DATA_WIDTH/8).
  - aw_burst/ar_burst = 2'b01 (INCR).
  - id = MASTER_ID.
- 4 KB boundary crossing is not split; the command issuer guarantees none.
- AW state: aw_valid = 1 and is held stable until aw_ready; then go to W. AR state behaves the same way with ar_valid, then goes to R.
- W state:
  - Combinational pass-through: w_valid = wd_valid, wd_ready = w_ready, w_data = wd_data, w_strb = wd_strb.
  - w_last = (count == len).
  - Counter increments on each w handshake; on the last handshake go to B.
  - wd_ready = 0 outside W.
- B state:
  - b_ready = 1.
  - On b_valid: done = 1 for one cycle, done_resp = b_resp, done_err = (b_id != MASTER_ID); return to IDLE.
- R state:
  - Pass-through: rd_valid = r_valid, r_ready = rd_ready, rd_data = r_data.
  - rd_last = (count == len).
  - Counter increments per handshake.
  - done_resp records the first non-OKAY r_resp seen; it stays OKAY otherwise.
  - done_err is sticky-set if any beat has r_id != MASTER_ID, or r_last != (count == len).
  - The burst ends on the handshake where count == len, irrespective of r_last. done pulses the following cycle and state returns to IDLE.
- Latency:
  - Command accept to aw_valid/ar_valid: 1 cycle.
  - Final B/R handshake to done: 1 cycle.
  - done_resp/done_err are valid only while done = 1. They hold their value until the next command is accepted.
- len = 0: a single beat, with w_last/rd_last asserted on the first beat.
- len = 255: 256 beats; the 8-bit counter must not wrap before the final beat.
- Backpressure on either side (w_ready, wd_valid, rd_ready, r_valid low) stalls with no beat lost or duplicated.
- No new command is accepted until done has pulsed.

Test Plan:
- Reset mid-burst:
  - Stimulus: write len=7 in progress at beat 3, assert rst=0 for 1 cycle.
  - Required: next cycle state IDLE, w_valid=0, aw_valid=0, cmd_ready=1; done never pulses.
- Write, single beat:
  - Stimulus: cmd_write=1, addr=0x1004, len=0, DATA_WIDTH=64; slave drives b_resp=0.
  - Required: aw_addr=0x1000, aw_size=3, aw_burst=1, w_last on first beat, done=1 with done_resp=0, done_err=0.
- Write, 4 beats with throttling:
  - Stimulus: len=3, data 0xA0..0xA3; w_ready toggles 1/0 each cycle.
  - Required: exactly 4 w handshakes in order, w_last only on 0xA3, b_ready high only in B.
- Read, 8 beats with consumer backpressure:
  - Stimulus: len=7; rd_ready low for 2 cycles at beat 4.
  - Required: rd_data order preserved, rd_last on beat 8; r_resp=2 on beat 5 gives done_resp=2.
- Protocol errors:
  - Stimulus: read len=3 with r_last asserted on beat 2; separately, a write with b_id=1 while MASTER_ID=0.
  - Required: done_err=1 in both cases; the read still completes after 4 beats.
- Maximum length:
  - Stimulus: read len=255.
  - Required: 256 beats, rd_last only on beat 256, cmd_ready low throughout until done.
